bus_rr_arbiter: RTL and testbench

Central controller for the shared broadcast bus that connects DRVRS driver/monitor FIFOs.
- Round-robin selects one source with a pending packet and pops its head entry.
- Decodes the destination id in the packet header.
- Pushes the packet to the destination port, to all ports except the source on broadcast, or drops it if the id is invalid.
- Sits between the per-driver FIFOs and the per-driver receive path; it is the block the Driver_Monitor bench exercises.

---
 rtl/bus_pkg.sv | 20 ++
 rtl/rr_picker.sv | 31 +++
 rtl/bus_rr_arbiter.sv | 109 ++++++++++
 tb/tb_bus_rr_arbiter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types and helpers for the broadcast-bus arbiter.
package bus_pkg;

    localparam int ID_W    = 8;
    localparam int PKT_MAX = 64;
    localparam logic [ID_W-1:0] BROADCAST_ID = 8'hFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        DELIVER = 2'd2
    } state_t;

    // Header id sits in the top ID_W bits of a pkt_w-wide packet.
    function automatic logic [ID_W-1:0] get_dest(input logic [PKT_MAX-1:0] pkt,
                                                 input int unsigned pkt_w);
        return pkt[pkt_w-1 -: ID_W];
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester after last_grant, wrapping.
module rr_picker
    import bus_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_grant,
    output logic             valid,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] index
);

    always_comb begin
        valid = 1'b0;
        gnt   = '0;
        index = '0;
        for (int k = 1; k <= N; k++) begin
            int c;
            c = int'(last_grant) + k;
            if (c >= N) c = c - N;
            if (!valid && req[c]) begin
                valid  = 1'b1;
                gnt[c] = 1'b1;
                index  = IDX_W'(c);
            end
        end
    end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin bus arbiter: pop one FIFO head, decode its destination, push it out.
module bus_rr_arbiter
    import bus_pkg::*;
#(
    parameter int              DRVRS     = 4,
    parameter int              PCKG_SZ   = 16,
    parameter logic [ID_W-1:0] BROADCAST = BROADCAST_ID
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DRVRS-1:0]           pndng,
    input  logic [DRVRS*PCKG_SZ-1:0]   d_pop,
    output logic [DRVRS-1:0]           pop,
    output logic [DRVRS-1:0]           push,
    output logic [PCKG_SZ-1:0]         d_push,
    output logic                       busy,
    output logic                       drop_err
);

    localparam int IDX_W = (DRVRS > 1) ? $clog2(DRVRS) : 1;

    state_t              state;
    logic [PCKG_SZ-1:0]  pkt;
    logic [IDX_W-1:0]    src;
    logic [IDX_W-1:0]    last_grant;

    logic                pick_vld;
    logic [DRVRS-1:0]    pick_gnt;
    logic [IDX_W-1:0]    pick_idx;
    logic [PCKG_SZ-1:0]  head;

    logic [ID_W-1:0]     dest;
    logic [DRVRS-1:0]    mask;
    logic                bad;

    rr_picker #(.N(DRVRS), .IDX_W(IDX_W)) u_pick (
        .req        (pndng),
        .last_grant (last_grant),
        .valid      (pick_vld),
        .gnt        (pick_gnt),
        .index      (pick_idx)
    );

    always_comb begin
        head = d_pop[pick_idx*PCKG_SZ +: PCKG_SZ];
    end

    // Destination decode of the latched packet, used on the GRANT exit edge.
    always_comb begin
        dest = get_dest(PKT_MAX'(pkt), PCKG_SZ);
        mask = '0;
        bad  = 1'b0;
        if (dest == BROADCAST) begin
            mask      = '1;
            mask[src] = 1'b0;
        end else if (int'(dest) < DRVRS) begin
            mask[dest[IDX_W-1:0]] = 1'b1;
        end else begin
            bad = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            pkt        <= '0;
            src        <= '0;
            last_grant <= IDX_W'(DRVRS-1);
            pop        <= '0;
            push       <= '0;
            d_push     <= '0;
            busy       <= 1'b0;
            drop_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        pkt        <= head;
                        src        <= pick_idx;
                        last_grant <= pick_idx;
                        pop        <= pick_gnt;
                        busy       <= 1'b1;
                        state      <= GRANT;
                    end
                end
                GRANT: begin
                    pop      <= '0;
                    push     <= mask;
                    d_push   <= pkt;
                    drop_err <= bad;
                    state    <= DELIVER;
                end
                DELIVER: begin
                    push     <= '0;
                    drop_err <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    pop   <= '0;
                    push  <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter with hand-computed expectations.
module tb_bus_rr_arbiter;

    localparam int DRVRS   = 4;
    localparam int PCKG_SZ = 16;

    logic                     clk;
    logic                     rst;
    logic [DRVRS-1:0]         pndng;
    logic [DRVRS*PCKG_SZ-1:0] d_pop;
    logic [DRVRS-1:0]         pop;
    logic [DRVRS-1:0]         push;
    logic [PCKG_SZ-1:0]       d_push;
    logic                     busy;
    logic                     drop_err;

    int n_chk  = 0;
    int n_pass = 0;
    int pop0_cnt = 0;

    bus_rr_arbiter #(.DRVRS(DRVRS), .PCKG_SZ(PCKG_SZ), .BROADCAST(8'hFF)) dut (
        .clk      (clk),
        .rst      (rst),
        .pndng    (pndng),
        .d_pop    (d_pop),
        .pop      (pop),
        .push     (push),
        .d_push   (d_push),
        .busy     (busy),
        .drop_err (drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (rst && pop[0]) pop0_cnt <= pop0_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pkt(input int i, input logic [PCKG_SZ-1:0] v);
        d_pop[i*PCKG_SZ +: PCKG_SZ] = v;
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        chk("rst_pop", 32'(pop), 0);
        chk("rst_push", 32'(push), 0);
        chk("rst_busy", 32'(busy), 0);
        #3 rst = 1'b1;
        tick();
    endtask

    initial begin
        rst   = 1'b0;
        pndng = '0;
        d_pop = '0;
        #1;
        chk("init_pop", 32'(pop), 0);
        chk("init_push", 32'(push), 0);
        chk("init_dpush", 32'(d_push), 0);
        chk("init_busy", 32'(busy), 0);
        chk("init_drop", 32'(drop_err), 0);
        #13 rst = 1'b1;
        tick();

        // Single packet to port 2
        set_pkt(0, 16'h02AB);
        pndng = 4'b0001;
        tick();
        chk("sp_pop", 32'(pop), 32'b0001);
        chk("sp_busy1", 32'(busy), 1);
        chk("sp_push0", 32'(push), 0);
        pndng = 4'b0000;
        tick();
        chk("sp_pop_off", 32'(pop), 0);
        chk("sp_push", 32'(push), 32'b0100);
        chk("sp_dpush", 32'(d_push), 32'h02AB);
        chk("sp_busy2", 32'(busy), 1);
        tick();
        chk("sp_push_off", 32'(push), 0);
        chk("sp_busy_off", 32'(busy), 0);
        chk("sp_dpush_hold", 32'(d_push), 32'h02AB);
        tick();
        chk("sp_pop0_once", 32'(pop0_cnt), 1);

        // Fairness with all ports pending
        do_reset();
        for (int i = 0; i < DRVRS; i++) set_pkt(i, PCKG_SZ'(((i + 1) % DRVRS) << 8));
        pndng = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("fair_pop%0d", k), 32'(pop), 32'(1 << (k % 4)));
            tick();
            chk($sformatf("fair_push%0d", k), 32'(push), 32'(1 << ((k % 4 + 1) % 4)));
            tick();
            chk($sformatf("fair_gap%0d", k), 32'({pop, push}), 0);
        end
        pndng = '0;
        tick();

        // Broadcast from port 2
        do_reset();
        set_pkt(2, 16'hFF55);
        pndng = 4'b0100;
        tick();
        chk("bc_pop", 32'(pop), 32'b0100);
        pndng = '0;
        tick();
        chk("bc_push", 32'(push), 32'b1011);
        chk("bc_dpush", 32'(d_push), 32'hFF55);
        chk("bc_drop", 32'(drop_err), 0);
        tick();
        chk("bc_push_off", 32'(push), 0);

        // Invalid destination from port 3
        set_pkt(3, 16'h0711);
        pndng = 4'b1000;
        tick();
        chk("inv_pop", 32'(pop), 32'b1000);
        chk("inv_drop0", 32'(drop_err), 0);
        pndng = '0;
        tick();
        chk("inv_push", 32'(push), 0);
        chk("inv_drop1", 32'(drop_err), 1);
        tick();
        chk("inv_drop_off", 32'(drop_err), 0);
        chk("inv_busy_off", 32'(busy), 0);

        // Reset while delivering
        set_pkt(0, 16'h0100);
        set_pkt(1, 16'h0000);
        pndng = 4'b0001;
        tick();
        chk("mr_pop", 32'(pop), 32'b0001);
        tick();
        chk("mr_push", 32'(push), 32'b0010);
        rst = 1'b0;
        #1;
        chk("mr_push_clr", 32'(push), 0);
        chk("mr_pop_clr", 32'(pop), 0);
        chk("mr_busy_clr", 32'(busy), 0);
        pndng = 4'b0011;
        #4 rst = 1'b1;
        tick();
        chk("mr_first_gnt", 32'(pop), 32'b0001);
        pndng = '0;
        tick();
        tick();
        tick();

        // Wrap (pointer at 3) and loopback on port 3
        do_reset();
        set_pkt(0, 16'h0100);
        set_pkt(3, 16'h0300);
        pndng = 4'b1001;
        tick();
        chk("wr_pop0", 32'(pop), 32'b0001);
        tick();
        chk("wr_push0", 32'(push), 32'b0010);
        tick();
        tick();
        chk("wr_pop3", 32'(pop), 32'b1000);
        pndng = '0;
        tick();
        chk("lb_push", 32'(push), 32'b1000);
        chk("lb_dpush", 32'(d_push), 32'h0300);
        tick();
        chk("lb_idle", 32'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
